// File: rtl/conv3x3_pkg.sv
// Shared constants and kernel type for the 3x3 convolution engine.
package conv3x3_pkg;

    localparam int PIX_W   = 12;
    localparam int COEF_W  = 8;
    localparam int NTAPS   = 9;
    localparam int PROD_W  = 21;
    localparam int SUM_W   = 25;
    localparam int SHIFT_W = 4;
    localparam int PIX_MAX = 4095;

    typedef struct packed {
        logic [NTAPS-1:0][COEF_W-1:0] coef;
        logic [SHIFT_W-1:0]           shift;
    } kernel_t;

    // Centre tap (k=4) is 1, all others 0, no shift.
    localparam kernel_t KERNEL_IDENT = '{coef: 72'h000000000100000000, shift: 4'd0};

endpackage

// File: rtl/conv3x3_round_clamp.sv
// Output stage datapath: round-half-up, arithmetic right shift, clamp to pixel range.
module conv3x3_round_clamp
    import conv3x3_pkg::*;
(
    input  logic signed [SUM_W-1:0]   sum_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic        [PIX_W-1:0]   pix_o,
    output logic                      sat_o
);

    localparam logic signed [SUM_W:0] RND_ONE = (SUM_W+1)'(1);
    localparam logic signed [SUM_W:0] MAX_S   = (SUM_W+1)'(PIX_MAX);

    function automatic logic signed [SUM_W:0] round_shift(
        input logic signed [SUM_W-1:0]   s,
        input logic        [SHIFT_W-1:0] sh
    );
        logic signed [SUM_W:0] t;
        logic signed [SUM_W:0] rnd;
        t   = {s[SUM_W-1], s};
        rnd = '0;
        if (sh != '0)
            rnd = RND_ONE << (sh - 1'b1);
        t = t + rnd;
        return t >>> sh;
    endfunction

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SUM_W:0] v);
        if (v[SUM_W])
            return '0;
        else if (v > MAX_S)
            return PIX_W'(PIX_MAX);
        else
            return v[PIX_W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [SUM_W:0] v);
        return v[SUM_W] || (v > MAX_S);
    endfunction

    logic signed [SUM_W:0] shifted;

    always_comb begin
        shifted = round_shift(sum_i, shift_i);
        pix_o   = clamp_pix(shifted);
        sat_o   = is_sat(shifted);
    end

endmodule

// File: rtl/axis_conv3x3.sv
// AXI4-Stream 3x3 convolution: one window in, one clamped pixel out, 3-stage pipe
// with a drain-then-swap coefficient shadow register.
module axis_conv3x3
    import conv3x3_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 108,
    parameter int M_AXIS_TDATA_WIDTH = 16,
    parameter int CNT_W              = 16
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                            s00_axis_tvalid,
    output logic                            s00_axis_tready,
    input  logic                            s00_axis_tlast,
    output logic [M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,
    output logic                            m00_axis_tlast,
    input  logic [NTAPS*COEF_W-1:0]         coef_data,
    input  logic [SHIFT_W-1:0]              coef_shift,
    input  logic                            coef_wr,
    output logic [CNT_W-1:0]                beat_count,
    output logic [CNT_W-1:0]                frame_count,
    output logic [CNT_W-1:0]                sat_count
);

    logic    en, accept, apply;
    kernel_t active_q, shadow_q;
    logic    pending_q;

    logic                      vld_p1_q, vld_p2_q, vld_p3_q;
    logic                      last_p1_q, last_p2_q, last_p3_q;
    logic        [SHIFT_W-1:0] shift_p1_q, shift_p2_q;
    logic signed [PROD_W-1:0]  prod_p1_d [NTAPS];
    logic signed [PROD_W-1:0]  prod_p1_q [NTAPS];
    logic signed [SUM_W-1:0]   sum_p2_d, sum_p2_q;
    logic        [PIX_W-1:0]   pix_p3_d, pix_p3_q;
    logic                      sat_p3_d;
    logic        [CNT_W-1:0]   beat_q, frame_q, sat_q;

    assign en              = ~vld_p3_q | m00_axis_tready;
    assign s00_axis_tready = en & ~pending_q;
    assign accept          = s00_axis_tvalid & s00_axis_tready;
    assign apply           = pending_q & ~(vld_p1_q | vld_p2_q | vld_p3_q);

    // Stage 1: unsigned pixel (zero-extended) times signed coefficient
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod_p1_d[k] = $signed({{(PROD_W-PIX_W){1'b0}}, s00_axis_tdata[k*PIX_W +: PIX_W]})
                         * $signed({{(PROD_W-COEF_W){active_q.coef[k][COEF_W-1]}}, active_q.coef[k]});
        end
    end

    // Stage 2: sum of products
    always_comb begin
        sum_p2_d = '0;
        for (int k = 0; k < NTAPS; k++)
            sum_p2_d = sum_p2_d + SUM_W'(prod_p1_q[k]);
    end

    // Stage 3: round, shift, clamp
    conv3x3_round_clamp u_round_clamp (
        .sum_i   (sum_p2_q),
        .shift_i (shift_p2_q),
        .pix_o   (pix_p3_d),
        .sat_o   (sat_p3_d)
    );

    always_ff @(posedge axis_aclk) begin
        if (en) begin
            prod_p1_q  <= prod_p1_d;
            last_p1_q  <= s00_axis_tlast;
            shift_p1_q <= active_q.shift;
            sum_p2_q   <= sum_p2_d;
            last_p2_q  <= last_p1_q;
            shift_p2_q <= shift_p1_q;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            pix_p3_q  <= '0;
            last_p3_q <= 1'b0;
            beat_q    <= '0;
            frame_q   <= '0;
            sat_q     <= '0;
            pending_q <= 1'b0;
            active_q  <= KERNEL_IDENT;
            shadow_q  <= KERNEL_IDENT;
        end else begin
            if (en) begin
                vld_p1_q <= accept;
                vld_p2_q <= vld_p1_q;
                vld_p3_q <= vld_p2_q;
                if (vld_p2_q) begin
                    pix_p3_q  <= pix_p3_d;
                    last_p3_q <= last_p2_q;
                end
            end
            if (en && vld_p2_q && sat_p3_d && (sat_q != '1))
                sat_q <= sat_q + CNT_W'(1);
            if (accept) begin
                beat_q <= beat_q + CNT_W'(1);
                if (s00_axis_tlast)
                    frame_q <= frame_q + CNT_W'(1);
            end
            // A write landing on the apply cycle keeps pending so the newer shadow follows.
            if (coef_wr) begin
                shadow_q  <= {coef_data, coef_shift};
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
            if (apply)
                active_q <= shadow_q;
        end
    end

    assign m00_axis_tdata  = M_AXIS_TDATA_WIDTH'(pix_p3_q);
    assign m00_axis_tstrb  = '1;
    assign m00_axis_tvalid = vld_p3_q;
    assign m00_axis_tlast  = last_p3_q;
    assign beat_count      = beat_q;
    assign frame_count     = frame_q;
    assign sat_count       = sat_q;

endmodule

// File: tb/tb_axis_conv3x3.sv
// Directed self-checking bench for axis_conv3x3.
module tb_axis_conv3x3;

    logic         clk = 1'b0;
    logic         rst;
    logic [107:0] s_tdata;
    logic         s_tvalid, s_tready, s_tlast;
    logic [15:0]  m_tdata;
    logic [1:0]   m_tstrb;
    logic         m_tvalid, m_tready, m_tlast;
    logic [71:0]  coef_data;
    logic [3:0]   coef_shift;
    logic         coef_wr;
    logic [15:0]  beat_count, frame_count, sat_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [107:0] in_data_q [$];
    logic         in_last_q [$];
    logic [15:0]  out_data_q [$];
    logic         out_last_q [$];

    always #5 clk = ~clk;

    axis_conv3x3 dut (
        .axis_aclk       (clk),
        .axis_reset      (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast),
        .coef_data       (coef_data),
        .coef_shift      (coef_shift),
        .coef_wr         (coef_wr),
        .beat_count      (beat_count),
        .frame_count     (frame_count),
        .sat_count       (sat_count)
    );

    function automatic logic [107:0] win(input logic [11:0] c, input logic [11:0] o);
        logic [107:0] r;
        for (int k = 0; k < 9; k++) r[k*12 +: 12] = (k == 4) ? c : o;
        return r;
    endfunction

    function automatic logic [71:0] kern(input logic [7:0] c, input logic [7:0] o);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = (k == 4) ? c : o;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; coef_wr = 1'b0; m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_kernel(input logic [71:0] c, input logic [3:0] sh, output bit ok);
        coef_data = c; coef_shift = sh; coef_wr = 1'b1;
        @(posedge clk); #1;
        coef_wr = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_tready === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Drives in_data_q and gathers handshaked outputs; also verifies output hold while stalled.
    task automatic run_stream(input bit toggle);
        int idx = 0;
        bit held = 1'b0;
        logic [15:0] held_d;
        logic held_l;
        out_data_q.delete(); out_last_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            s_tvalid = (idx < in_data_q.size());
            s_tdata  = s_tvalid ? in_data_q[idx] : '0;
            s_tlast  = s_tvalid ? in_last_q[idx] : 1'b0;
            m_tready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (held) begin
                vectors++;
                if (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tlast !== held_l) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                             m_tvalid, m_tdata, m_tlast, held_d, held_l);
                end
                held = 1'b0;
            end
            if (m_tvalid === 1'b1) begin
                if (m_tready) begin
                    out_data_q.push_back(m_tdata); out_last_q.push_back(m_tlast);
                end else begin
                    held = 1'b1; held_d = m_tdata; held_l = m_tlast;
                end
            end
            if (s_tvalid && s_tready === 1'b1) idx++;
            @(posedge clk); #1;
            if (idx == in_data_q.size() && out_data_q.size() >= in_data_q.size()) break;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({m_tvalid, m_tlast, m_tdata} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_out: got valid=%0b last=%0b data=%h, want 0/0/0000", m_tvalid, m_tlast, m_tdata);
        end
        vectors++;
        if ({beat_count, frame_count, sat_count} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %h/%h/%h, want 0/0/0", beat_count, frame_count, sat_count);
        end
        vectors++;
        if (s_tready !== 1'b1 || m_tstrb !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_ready_strb: got ready=%0b strb=%b, want 1/11", s_tready, m_tstrb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        logic [2:0] seen;
        s_tvalid = 1'b1; s_tdata = win(12'h123, 12'hFFF); s_tlast = 1'b0; m_tready = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_tready !== 1'b1) begin
            miscompares++; $display("FAIL ident_ready: got %0b, want 1", s_tready);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        seen = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = m_tvalid;
            if (i < 2) begin @(posedge clk); #1; end
        end
        vectors++;
        if (seen !== 3'b100) begin
            miscompares++; $display("FAIL ident_latency: got valid pattern %b, want 100", seen);
        end
        vectors++;
        if (m_tdata !== 16'h0123) begin
            miscompares++; $display("FAIL ident_data: got %h, want 0123", m_tdata);
        end
        vectors++;
        if (sat_count !== 16'd0 || beat_count !== 16'd1) begin
            miscompares++; $display("FAIL ident_cnt: got sat=%0d beat=%0d, want 0/1", sat_count, beat_count);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (m_tvalid !== 1'b0) begin
            miscompares++; $display("FAIL ident_single: got valid=%0b, want 0", m_tvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_kernels();
        bit ok;
        logic [15:0] exp3 [3];
        load_kernel(kern(8'd1, 8'd1), 4'd3, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL box_load: got ready=0, want 1 within budget"); end
        in_data_q = '{win(12'd100, 12'd100)}; in_last_q = '{1'b0};
        run_stream(1'b0);
        vectors++;
        if (out_data_q.size() != 1 || out_data_q[0] !== 16'h0071) begin
            miscompares++; $display("FAIL box_data: got n=%0d data=%h, want n=1 data=0071",
                                    out_data_q.size(), out_data_q.size() > 0 ? out_data_q[0] : 16'hxxxx);
        end
        load_kernel(kern(8'd8, 8'hFF), 4'd0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL lap_load: got ready=0, want 1 within budget"); end
        in_data_q = '{win(12'd4095, 12'd4095), win(12'd4095, 12'd0), win(12'd0, 12'd4095)};
        in_last_q = '{1'b0, 1'b0, 1'b0};
        exp3 = '{16'h0000, 16'h0FFF, 16'h0000};
        run_stream(1'b0);
        vectors++;
        if (out_data_q.size() != 3) begin
            miscompares++; $display("FAIL lap_count: got %0d, want 3", out_data_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (out_data_q[i] !== exp3[i]) begin
                    miscompares++; $display("FAIL lap_data%0d: got %h, want %h", i, out_data_q[i], exp3[i]);
                end
            end
        end
        vectors++;
        if (sat_count !== 16'd2 || beat_count !== 16'd5 || frame_count !== 16'd0) begin
            miscompares++; $display("FAIL lap_cnt: got sat=%0d beat=%0d frame=%0d, want 2/5/0",
                                    sat_count, beat_count, frame_count);
        end
    endtask

    task automatic test_stream_stall();
        do_reset();
        in_data_q.delete(); in_last_q.delete();
        for (int i = 0; i < 10; i++) begin
            in_data_q.push_back(win(12'(12'h100 + i * 12'h11), 12'hABC));
            in_last_q.push_back(i == 9);
        end
        run_stream(1'b1);
        vectors++;
        if (out_data_q.size() != 10) begin
            miscompares++; $display("FAIL stream_count: got %0d, want 10", out_data_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (out_data_q[i] !== 16'(16'h100 + i * 16'h11) || out_last_q[i] !== (i == 9)) begin
                    miscompares++;
                    $display("FAIL stream_beat%0d: got data=%h last=%0b, want data=%h last=%0b",
                             i, out_data_q[i], out_last_q[i], 16'(16'h100 + i * 16'h11), (i == 9));
                end
            end
        end
        vectors++;
        if (frame_count !== 16'd1 || beat_count !== 16'd10) begin
            miscompares++; $display("FAIL stream_cnt: got frame=%0d beat=%0d, want 1/10", frame_count, beat_count);
        end
    endtask

    task automatic test_coef_update();
        int blocked = 0;
        bit accepted = 1'b0;
        logic [15:0] exp4 [4];
        exp4 = '{16'd10, 16'd20, 16'd30, 16'd80};
        out_data_q.delete();
        m_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_tvalid = 1'b1; s_tdata = win(12'(10 * (b + 1)), 12'd0); s_tlast = 1'b0;
            if (b == 2) begin coef_data = kern(8'd2, 8'd0); coef_shift = 4'd0; coef_wr = 1'b1; end
            @(negedge clk);
            if (s_tready !== 1'b1) blocked = blocked + 100;
            @(posedge clk); #1;
        end
        coef_wr = 1'b0;
        s_tdata = win(12'd40, 12'd0);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_tvalid === 1'b1) out_data_q.push_back(m_tdata);
            if (s_tvalid) begin
                if (s_tready === 1'b1) accepted = 1'b1;
                else blocked++;
            end
            @(posedge clk); #1;
            if (accepted) s_tvalid = 1'b0;
            if (out_data_q.size() >= 4) break;
        end
        s_tvalid = 1'b0;
        vectors++;
        if (blocked != 4) begin
            miscompares++; $display("FAIL coef_blocked: got %0d blocked cycles, want 4", blocked);
        end
        vectors++;
        if (out_data_q.size() != 4) begin
            miscompares++; $display("FAIL coef_count: got %0d, want 4", out_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (out_data_q[i] !== exp4[i]) begin
                    miscompares++; $display("FAIL coef_data%0d: got %h, want %h", i, out_data_q[i], exp4[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit stale = 1'b0;
        m_tready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            s_tvalid = 1'b1; s_tdata = win(12'(5 + b), 12'd0); s_tlast = 1'b1;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (m_tvalid !== 1'b0 || m_tdata !== 16'h0 || m_tlast !== 1'b0) begin
            miscompares++; $display("FAIL midrst_out: got valid=%0b data=%h last=%0b, want 0/0000/0",
                                    m_tvalid, m_tdata, m_tlast);
        end
        vectors++;
        if ({beat_count, frame_count, sat_count} !== 48'h0 || s_tready !== 1'b1) begin
            miscompares++; $display("FAIL midrst_cnt: got %0d/%0d/%0d ready=%0b, want 0/0/0 ready=1",
                                    beat_count, frame_count, sat_count, s_tready);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (m_tvalid !== 1'b0) stale = 1'b1;
        end
        vectors++;
        if (stale) begin miscompares++; $display("FAIL midrst_stale: got valid=1 after reset, want 0"); end
        @(posedge clk); #1;
        in_data_q = '{win(12'd7, 12'd0)}; in_last_q = '{1'b0};
        run_stream(1'b0);
        vectors++;
        if (out_data_q.size() != 1 || out_data_q[0] !== 16'h0007) begin
            miscompares++; $display("FAIL midrst_ident: got n=%0d data=%h, want n=1 data=0007",
                                    out_data_q.size(), out_data_q.size() > 0 ? out_data_q[0] : 16'hxxxx);
        end
    endtask

    initial begin
        rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        coef_data = '0; coef_shift = '0; coef_wr = 1'b0;
        test_reset();
        test_identity();
        test_kernels();
        test_stream_stall();
        test_coef_update();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us, want completion");
        $fatal(1);
    end

endmodule
